// File: rtl/fp_sort_engine.sv
// fp_sort_engine: frame buffer with odd-even transposition sort, largest first.
// Optional FP_SORT_EXP_ONLY_EN orders by exponent field only.
module fp_sort_engine #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 5,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W-1:0] out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int W  = EXP_W + MAN_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] TOP = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [W-1:0]  slot_q [DEPTH];
    logic [W-1:0]  slot_d [DEPTH];

    logic accept;
    logic out_fire;
    logic drain_end;

    function automatic logic [W-1:0] key_of(input logic [W-1:0] w);
`ifdef FP_SORT_EXP_ONLY_EN
        key_of = w >> MAN_W;
`else
        key_of = w;
`endif
    endfunction

    assign accept    = in_valid && (state_q == LOAD);
    assign out_fire  = out_ready && (state_q == DRAIN);
    assign drain_end = (rd_q == n_q - 1'b1);

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: close frame on in_last or full, drain after DEPTH phases.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = LOAD;
            LOAD: begin
                if (accept && (in_last || n_q == TOP)) begin
                    state_d = SORT;
                end
            end
            SORT: begin
                if (phase_q == TOP) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_fire && drain_end) begin
                    state_d = LOAD;
                end
            end
        endcase
    end

    // Output decode from state and drain pointer.
    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == DRAIN);
        busy      = (state_q == SORT);
        out_last  = (state_q == DRAIN) && drain_end;
        out_data  = '0;
        if (state_q == DRAIN) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(rd_q)) begin
                    out_data = slot_q[i];
                end
            end
        end
    end

    // Datapath next-state: slot writes, compare-swap phases, drain pointer.
    always_comb begin
        n_d     = n_q;
        phase_d = phase_q;
        rd_d    = rd_q;
        slot_d  = slot_q;
        unique case (state_q)
            IDLE: begin
                n_d = '0;
            end
            LOAD: begin
                phase_d = '0;
                rd_d    = '0;
                if (accept) begin
                    n_d = n_q + 1'b1;
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == int'(n_q)) begin
                            slot_d[i] = in_data;
                        end
                    end
                end
            end
            SORT: begin
                phase_d = phase_q + 1'b1;
                // pairs in one phase are disjoint, so swaps never collide
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if ((i % 2 == int'(phase_q[0]))
                        && (i + 1 < int'(n_q))
                        && (key_of(slot_q[i]) < key_of(slot_q[i+1]))) begin
                        slot_d[i]   = slot_q[i+1];
                        slot_d[i+1] = slot_q[i];
                    end
                end
            end
            DRAIN: begin
                if (out_fire) begin
                    rd_d = rd_q + 1'b1;
                    if (drain_end) begin
                        n_d  = '0;
                        rd_d = '0;
                    end
                end
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q     <= '0;
            phase_q <= '0;
            rd_q    <= '0;
            slot_q  <= '{default: '0};
        end else begin
            n_q     <= n_d;
            phase_q <= phase_d;
            rd_q    <= rd_d;
            slot_q  <= slot_d;
        end
    end

endmodule
